// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared screen defaults, coordinate-width helper and the
//                blitter state encoding for the VGA plot path.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

   localparam int c_scr_w_default    = 160;
   localparam int c_scr_h_default    = 120;
   localparam int c_colour_w_default = 3;

   // One spare bit beyond what the extent needs, so a coordinate one past the
   // screen edge is still representable.
   function automatic int coord_w(input int extent);
      return $clog2(extent) + 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/pix_delay.sv
`default_nettype none
// ============================================================================
//  Module      : pix_delay
//  Description : DEPTH-stage x WIDTH-bit shift register with synchronous
//                active-low clear. Keeps per-pixel side data in step with
//                the image memory read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_delay #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] w_tap [DEPTH+1];

   assign w_tap[0] = din;
   assign dout     = w_tap[DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] r_q;

      // One stage of the delay line; a clear empties every stage at once.
      always_ff @(posedge clk) begin
         if (!reset) begin
            r_q <= '0;
         end else begin
            r_q <= w_tap[gi];
         end
      end

      assign w_tap[gi+1] = r_q;
   end

endmodule
`default_nettype wire

// File: rtl/image_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : image_blitter
//  Description : Copies one IMG_W x IMG_H image from external image memory to
//                screen position (dst_x, dst_y) on a start pulse, one pixel
//                per cycle, with latency alignment, edge clipping and an
//                optional transparent colour key.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_blitter
   import vga_pkg::*;
#(
   parameter int                  SCR_W    = c_scr_w_default,
   parameter int                  SCR_H    = c_scr_h_default,
   parameter int                  IMG_W    = 160,
   parameter int                  IMG_H    = 120,
   parameter int                  COLOUR_W = c_colour_w_default,
   parameter int                  SEL_W    = 8,
   parameter int                  MEM_LAT  = 1,
   parameter int                  KEY_EN   = 0,
   parameter logic [COLOUR_W-1:0] KEY      = '0,
   localparam int                 XW       = coord_w(SCR_W),
   localparam int                 YW       = coord_w(SCR_H),
   localparam int                 AW       = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [SEL_W-1:0]    sel,
   input  logic [XW-1:0]       dst_x,
   input  logic [YW-1:0]       dst_y,
   output logic                busy,
   output logic                done,
   output logic [AW-1:0]       mem_addr,
   output logic [SEL_W-1:0]    mem_sel,
   input  logic [COLOUR_W-1:0] mem_data,
   output logic [XW-1:0]       oX,
   output logic [YW-1:0]       oY,
   output logic [COLOUR_W-1:0] oColour,
   output logic                oPlot
);

   localparam int              c_cw       = $clog2(IMG_W + 1);
   localparam int              c_rw       = $clog2(IMG_H + 1);
   localparam logic [c_cw-1:0] c_col_last = c_cw'(IMG_W - 1);
   localparam logic [c_rw-1:0] c_row_last = c_rw'(IMG_H - 1);
   localparam logic [AW-1:0]   c_row_step = AW'(IMG_W);
   localparam logic [XW:0]     c_scr_w    = (XW + 1)'(SCR_W);
   localparam logic [YW:0]     c_scr_h    = (YW + 1)'(SCR_H);
   localparam int              c_pipe_w   = 1 + (XW + 1) + (YW + 1);

   blit_state_t         r_state;
   blit_state_t         w_state_next;

   logic [c_cw-1:0]     r_col;
   logic [c_rw-1:0]     r_row;
   logic [AW-1:0]       r_row_base;
   logic [XW-1:0]       r_dst_x;
   logic [XW:0]         r_scr_x;
   logic [YW:0]         r_scr_y;
   logic                r_out_valid;

   logic                w_issue_valid;
   logic                w_col_wrap;
   logic                w_last_pix;
   logic                w_drain_done;
   logic [c_pipe_w-1:0] w_pipe_in;
   logic [c_pipe_w-1:0] w_pipe_out;
   logic                w_dly_valid;
   logic [XW:0]         w_dly_x;
   logic [YW:0]         w_dly_y;
   logic                w_keyed;
   logic                w_plot;

   // The address on mem_addr is a live pixel exactly while scanning.
   assign w_issue_valid = (r_state == SCAN);
   assign w_col_wrap    = (r_col == c_col_last);
   assign w_last_pix    = w_col_wrap && (r_row == c_row_last);

   // The last pixel sits in the output register and nothing valid follows it.
   assign w_drain_done  = r_out_valid && !w_dly_valid;

   assign busy = (r_state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: accept start only when idle, drain after the last issue.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start)        w_state_next = SCAN;
         SCAN:    if (w_last_pix)   w_state_next = DRAIN;
         DRAIN:   if (w_drain_done) w_state_next = IDLE;
         default:                   w_state_next = IDLE;
      endcase
   end

   // Raster walk: latch the request, then step col/row and the address
   // incrementally so no multiplier is needed.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_addr   <= '0;
         mem_sel    <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
         r_dst_x    <= '0;
         r_scr_x    <= '0;
         r_scr_y    <= '0;
      end else if (r_state == IDLE) begin
         if (start) begin
            mem_sel    <= sel;
            r_dst_x    <= dst_x;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            mem_addr   <= '0;
            r_scr_x    <= {1'b0, dst_x};
            r_scr_y    <= {1'b0, dst_y};
         end
      end else if (r_state == SCAN && !w_last_pix) begin
         if (w_col_wrap) begin
            r_col      <= '0;
            r_row      <= r_row + 1'b1;
            r_row_base <= r_row_base + c_row_step;
            mem_addr   <= r_row_base + c_row_step;
            r_scr_x    <= {1'b0, r_dst_x};
            r_scr_y    <= r_scr_y + 1'b1;
         end else begin
            r_col      <= r_col + 1'b1;
            mem_addr   <= mem_addr + 1'b1;
            r_scr_x    <= r_scr_x + 1'b1;
         end
      end
   end

   assign w_pipe_in = {w_issue_valid, r_scr_x, r_scr_y};

   pix_delay #(
      .DEPTH (MEM_LAT),
      .WIDTH (c_pipe_w)
   ) u_pix_delay (
      .clk   (clk),
      .reset (reset),
      .din   (w_pipe_in),
      .dout  (w_pipe_out)
   );

   assign {w_dly_valid, w_dly_x, w_dly_y} = w_pipe_out;

   assign w_keyed = (KEY_EN != 0) && (mem_data == KEY);
   assign w_plot  = w_dly_valid && (w_dly_x < c_scr_w) && (w_dly_y < c_scr_h) && !w_keyed;

   // Output register: every valid pixel updates the plot bus, clipped or
   // keyed ones simply leave the strobe low.
   always_ff @(posedge clk) begin
      if (!reset) begin
         oX          <= '0;
         oY          <= '0;
         oColour     <= '0;
         oPlot       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         oPlot       <= w_plot;
         r_out_valid <= w_dly_valid;
         if (w_dly_valid) begin
            oX      <= w_dly_x[XW-1:0];
            oY      <= w_dly_y[YW-1:0];
            oColour <= mem_data;
         end
      end
   end

   // One-cycle completion pulse, issued as the FSM leaves DRAIN.
   always_ff @(posedge clk) begin
      if (!reset) begin
         done <= 1'b0;
      end else begin
         done <= (r_state == DRAIN) && w_drain_done;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_image_blitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_image_blitter
//  Description : Self-checking bench for image_blitter. Several configurations
//                run side by side against a cycle-indexed reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_blitter;

   localparam int c_ncfg = 5;
   localparam int c_img_w  [c_ncfg] = '{4,  4,  4,   2,  160};
   localparam int c_img_h  [c_ncfg] = '{2,  2,  4,   2,  120};
   localparam int c_lat    [c_ncfg] = '{1,  1,  1,   3,  1};
   localparam int c_key_en [c_ncfg] = '{0,  1,  0,   1,  0};
   localparam int c_key    [c_ncfg] = '{0,  0,  0,   5,  0};
   localparam int c_dx0    [c_ncfg] = '{10, 10, 158, 20, 0};
   localparam int c_dy0    [c_ncfg] = '{5,  5,  118, 30, 0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Image memory contents: a fixed function of image select and address.
   function automatic int colour_of(input int s, input int a);
      return (a * 5 + s * 3 + a / 7) % 8;
   endfunction

   for (genvar gi = 0; gi < c_ncfg; gi++) begin : g_cfg
      localparam int c_iw   = c_img_w[gi];
      localparam int c_ih   = c_img_h[gi];
      localparam int c_l    = c_lat[gi];
      localparam int c_ken  = c_key_en[gi];
      localparam int c_kv   = c_key[gi];
      localparam int c_npix = c_iw * c_ih;
      localparam int c_aw   = $clog2(c_npix);

      logic              rst_n;
      logic              start;
      logic [7:0]        sel;
      logic [8:0]        dst_x;
      logic [7:0]        dst_y;
      logic              busy;
      logic              done;
      logic [c_aw-1:0]   mem_addr;
      logic [7:0]        mem_sel;
      logic [2:0]        mem_data;
      logic [8:0]        oX;
      logic [7:0]        oY;
      logic [2:0]        oColour;
      logic              oPlot;
      logic [c_aw-1:0]   q_addr [c_l];
      logic [7:0]        q_sel  [c_l];
      bit                fin;

      image_blitter #(
         .SCR_W    (160),
         .SCR_H    (120),
         .IMG_W    (c_iw),
         .IMG_H    (c_ih),
         .COLOUR_W (3),
         .SEL_W    (8),
         .MEM_LAT  (c_l),
         .KEY_EN   (c_ken),
         .KEY      (3'(c_kv))
      ) u_dut (
         .clk      (clk),
         .reset    (rst_n),
         .start    (start),
         .sel      (sel),
         .dst_x    (dst_x),
         .dst_y    (dst_y),
         .busy     (busy),
         .done     (done),
         .mem_addr (mem_addr),
         .mem_sel  (mem_sel),
         .mem_data (mem_data),
         .oX       (oX),
         .oY       (oY),
         .oColour  (oColour),
         .oPlot    (oPlot)
      );

      // Memory with c_l cycles of read latency.
      always @(posedge clk) begin
         q_addr[0] <= mem_addr;
         q_sel[0]  <= mem_sel;
         for (int i = 1; i < c_l; i++) begin
            q_addr[i] <= q_addr[i-1];
            q_sel[i]  <= q_sel[i-1];
         end
      end
      assign mem_data = 3'(colour_of(int'(q_sel[c_l-1]), int'(q_addr[c_l-1])));

      initial begin
         int    ncopy, dx, dy, s, spur, abort_j, len, p, x, y, col, plot, gap;
         string tag;
         fin   = 1'b0;
         rst_n = 1'b0;
         start = 1'b0;
         sel   = '0;
         dst_x = '0;
         dst_y = '0;
         repeat (3) @(negedge clk);
         tag = $sformatf("cfg%0d reset", gi);
         check({tag, " busy"},     int'(busy),     0);
         check({tag, " done"},     int'(done),     0);
         check({tag, " oPlot"},    int'(oPlot),    0);
         check({tag, " oX"},       int'(oX),       0);
         check({tag, " oY"},       int'(oY),       0);
         check({tag, " oColour"},  int'(oColour),  0);
         check({tag, " mem_addr"}, int'(mem_addr), 0);
         check({tag, " mem_sel"},  int'(mem_sel),  0);
         rst_n = 1'b1;

         ncopy = (c_npix > 100) ? 1 : 6;
         for (int c = 0; c < ncopy; c++) begin
            if (c == 0) begin
               dx = c_dx0[gi];
               dy = c_dy0[gi];
               s  = 0;
            end else begin
               dx = $urandom_range(0, 165);
               dy = $urandom_range(0, 125);
               s  = $urandom_range(0, 255);
            end
            spur    = (c % 2 == 1) ? $urandom_range(1, c_npix + c_l) : 0;
            abort_j = (gi == 0 && c == 0) ? 5 + c_l : 0;
            len     = c_npix + c_l + 2;
            start   = 1'b1;
            sel     = 8'(s);
            dst_x   = 9'(dx);
            dst_y   = 8'(dy);
            for (int j = 1; j <= len; j++) begin
               @(negedge clk);
               tag = $sformatf("cfg%0d copy%0d cyc%0d", gi, c, j);
               if (abort_j != 0 && j > abort_j) begin
                  check({tag, " busy"},     int'(busy),     0);
                  check({tag, " done"},     int'(done),     0);
                  check({tag, " oPlot"},    int'(oPlot),    0);
                  check({tag, " mem_addr"}, int'(mem_addr), 0);
                  check({tag, " mem_sel"},  int'(mem_sel),  0);
               end else begin
                  check({tag, " busy"}, int'(busy), int'(j <= c_npix + c_l + 1));
                  check({tag, " done"}, int'(done), int'(j == len));
                  if (j <= c_npix) check({tag, " mem_addr"}, int'(mem_addr), j - 1);
                  check({tag, " mem_sel"}, int'(mem_sel), s);
                  p = j - 2 - c_l;
                  if (p >= 0 && p < c_npix) begin
                     x    = dx + p % c_iw;
                     y    = dy + p / c_iw;
                     col  = colour_of(s, p);
                     plot = int'(x < 160 && y < 120 && !(c_ken != 0 && col == c_kv));
                     check({tag, " oPlot"},   int'(oPlot),   plot);
                     check({tag, " oX"},      int'(oX),      x % 512);
                     check({tag, " oY"},      int'(oY),      y % 256);
                     check({tag, " oColour"}, int'(oColour), col);
                  end else begin
                     check({tag, " oPlot"}, int'(oPlot), 0);
                  end
               end
               start = (j == spur);
               if (j == spur) begin
                  sel   = 8'($urandom);
                  dst_x = 9'($urandom);
                  dst_y = 8'($urandom);
               end
               rst_n = (j != abort_j);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
               @(negedge clk);
               tag = $sformatf("cfg%0d gap%0d", gi, c);
               check({tag, " busy"},  int'(busy),  0);
               check({tag, " done"},  int'(done),  0);
               check({tag, " oPlot"}, int'(oPlot), 0);
            end
         end
         fin = 1'b1;
      end
   end

   initial begin
      bit all_fin;
      all_fin = 1'b0;
      for (int t = 0; t < 40000 && !all_fin; t++) begin
         @(negedge clk);
         all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin &&
                   g_cfg[3].fin && g_cfg[4].fin;
      end
      check("all_configs_finished", int'(all_fin), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/image_blitter.md
Name: image_blitter

Overview:
- Parametrised successor to the free-running full-frame MIF scanner.
- On a start pulse, copies one IMG_W x IMG_H image from image memory to an arbitrary screen position (dst_x, dst_y).
- Supports image select, memory-latency alignment, screen-edge clipping, optional transparent colour key and a start/busy/done handshake.
- Sits between the game/state FSM and the VGA adapter plot interface. Image memory is external and driven through mem_addr/mem_sel.

Parameters:
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- IMG_W, 160, image width in pixels
- IMG_H, 120, image height in pixels
- COLOUR_W, 3, colour bits per pixel
- SEL_W, 8, image-select width (passed to memory chip-select)
- MEM_LAT, 1, memory read latency in cycles, address to data (>=1)
- KEY_EN, 0, 1 = pixels equal to KEY are not plotted
- KEY, 0, transparent colour value
- Derived: XW = $clog2(SCR_W)+1, YW = $clog2(SCR_H)+1, AW = $clog2(IMG_W*IMG_H)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- sel  in  SEL_W  image select, latched on accepted start
- dst_x  in  XW  top-left screen x, latched on accepted start
- dst_y  in  YW  top-left screen y, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last pixel is output
- mem_addr  out  AW  pixel address, row*IMG_W+col
- mem_sel  out  SEL_W  latched sel
- mem_data  in  COLOUR_W  pixel colour, valid MEM_LAT cycles after mem_addr
- oX  out  XW  plot x
- oY  out  YW  plot y
- oColour  out  COLOUR_W  plot colour
- oPlot  out  1  plot strobe

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; busy, done, oPlot, oX, oY, oColour, mem_addr and mem_sel all 0; all pipeline valid bits cleared. Reset mid-operation aborts the copy: no further plots, no done.
- States and transitions:
  - IDLE: start==1 at edge k latches sel, dst_x, dst_y and moves to SCAN. start in any other state is ignored, with no queuing.
  - SCAN: one pixel per cycle in raster order (col 0..IMG_W-1, then row++). After pixel IMG_W*IMG_H-1 is issued, move to DRAIN.
  - DRAIN: wait for the pipeline to empty, then pulse done for 1 cycle and return to IDLE. busy is low in the done cycle.
- Address generation: incremental only (col++, row base += IMG_W). No multiplier. mem_addr for pixel p=row*IMG_W+col is driven during cycle k+1+p.
- Alignment pipeline: a MEM_LAT-deep shift of {valid, scr_x, scr_y} runs alongside the memory read.
- Screen coordinates: scr_x = dst_x+col and scr_y = dst_y+row, computed at XW+1 / YW+1 bits so overflow cannot wrap.
- Output register, pixel p, in cycle k+2+p+MEM_LAT:
  - oX/oY take scr_x/scr_y truncated to XW/YW.
  - oColour takes mem_data.
  - oPlot = valid AND scr_x<SCR_W AND scr_y<SCR_H AND NOT(KEY_EN AND mem_data==KEY).
- Clipped or keyed pixels still take their cycle; oPlot is 0 and oX/oY/oColour still update.
- oPlot is 0 in IDLE and while the pipeline holds no valid pixels.
- done is high in cycle k+2+IMG_W*IMG_H+MEM_LAT, i.e. one cycle after the last pixel output.
- Back-to-back: start may be accepted in the cycle immediately after done.
- A 1x1 image is legal: SCAN lasts one cycle.

Decomposition:
- Shared package vga_pkg: SCR_W/SCR_H defaults, COLOUR_W, XW/YW width functions, state enum {IDLE, SCAN, DRAIN}.
- One sub-module, pix_delay: parametrised DEPTH x WIDTH shift register with synchronous active-low clear, used for the {valid,x,y} alignment.

Test Plan:
- IMG 4x2, dst (10,5), MEM_LAT=1, KEY_EN=0, start at edge k -> mem_addr 0..7 in cycles k+1..k+8. oPlot high in cycles k+3..k+10 with (oX,oY) = (10,5),(11,5),(12,5),(13,5),(10,6)..(13,6) and oColour = memory contents. done in cycle k+11. busy high k+1..k+10.
- Same as above with KEY_EN=1, KEY=0, memory holding 0 at addresses 2 and 5 -> oPlot low for (12,5) and (11,6), all others plotted, done timing unchanged.
- dst_x=158, dst_y=118, IMG 4x4 -> only (158,118),(159,118),(158,119),(159,119) plotted; no wraparound to x=0; done at k+2+16+MEM_LAT.
- MEM_LAT=3, IMG 2x2 -> first oPlot in cycle k+5, done in cycle k+9. A start pulse during busy is ignored, so no second copy occurs.
- Reset driven low in the cycle after the 3rd pixel output of a 4x2 copy -> next edge gives oPlot=0, busy=0, done never pulses. A fresh start then runs a full 8-pixel copy.
- Full screen 160x120 at (0,0), MEM_LAT=1 -> mem_addr runs 0..19199 contiguously. oX wraps 159->0 with oY++. The last plot is (159,119). done in cycle k+19203.
